// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: claims the bus, shifts one byte with odd
// parity on device clock falls, then checks the device acknowledge.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 4800,
    parameter int TIMEOUT_CYCLES = 600000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] TX_DATA,
    input  logic       TX_VALID,
    output logic       TX_READY,
    output logic       TX_BUSY,
    output logic       TX_DONE,
    output logic       TX_ERROR,
    input  logic       PS2_CLK_IN,
    input  logic       PS2_DATA_IN,
    output logic       PS2_CLK_OE,
    output logic       PS2_DATA_OE
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [INH_W-1:0] INH_LAST  = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [INH_W-1:0] INH_START = INH_W'(INHIBIT_CYCLES - 2);
    localparam logic [TO_W-1:0]  TO_MAX    = TO_W'(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0]  TO_FIRE   = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, INHIBIT, SHIFT, ACK, WAIT_IDLE} state_t;

    state_t            state;
    logic              clk_meta, clk_sync, clk_prev;
    logic              data_meta, data_sync;
    logic              fall;
    logic              timed_out;
    logic              idle_ok;
    logic [9:0]        shreg;
    logic [3:0]        bit_cnt;
    logic [INH_W-1:0]  inh_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic              ack_ok;

    assign fall      = clk_prev & ~clk_sync;
    assign timed_out = (to_cnt >= TO_FIRE);
    assign idle_ok   = (state == WAIT_IDLE) && clk_sync && data_sync;

    // Presetting to 1 keeps a released bus from looking like a falling edge.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            clk_meta  <= 1'b1;
            clk_sync  <= 1'b1;
            clk_prev  <= 1'b1;
            data_meta <= 1'b1;
            data_sync <= 1'b1;
        end else begin
            clk_meta  <= PS2_CLK_IN;
            clk_sync  <= clk_meta;
            clk_prev  <= clk_sync;
            data_meta <= PS2_DATA_IN;
            data_sync <= data_meta;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state       <= IDLE;
            TX_READY    <= 1'b0;
            TX_BUSY     <= 1'b0;
            TX_DONE     <= 1'b0;
            TX_ERROR    <= 1'b0;
            PS2_CLK_OE  <= 1'b0;
            PS2_DATA_OE <= 1'b0;
            shreg       <= '0;
            bit_cnt     <= '0;
            inh_cnt     <= '0;
            to_cnt      <= '0;
            ack_ok      <= 1'b0;
        end else begin
            TX_DONE  <= 1'b0;
            TX_ERROR <= 1'b0;
            case (state)
                IDLE: begin
                    if (TX_VALID && TX_READY) begin
                        shreg      <= {1'b1, ~^TX_DATA, TX_DATA};
                        bit_cnt    <= '0;
                        inh_cnt    <= '0;
                        PS2_CLK_OE <= 1'b1;
                        TX_READY   <= 1'b0;
                        TX_BUSY    <= 1'b1;
                        state      <= INHIBIT;
                    end else begin
                        TX_READY <= 1'b1;
                    end
                end
                INHIBIT: begin
                    if (inh_cnt == INH_LAST) begin
                        PS2_CLK_OE <= 1'b0;
                        to_cnt     <= '0;
                        state      <= SHIFT;
                    end else begin
                        inh_cnt <= inh_cnt + 1'b1;
                        // Start bit goes out one cycle before the clock is released.
                        if (inh_cnt == INH_START) begin
                            PS2_DATA_OE <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    if (fall) begin
                        bit_cnt     <= bit_cnt + 1'b1;
                        PS2_DATA_OE <= ~shreg[0];
                        shreg       <= {1'b0, shreg[9:1]};
                        if (bit_cnt == 4'd9) begin
                            state <= ACK;
                        end
                    end
                end
                ACK: begin
                    if (fall) begin
                        bit_cnt <= bit_cnt + 1'b1;
                        ack_ok  <= ~data_sync;
                        state   <= WAIT_IDLE;
                    end
                end
                WAIT_IDLE: begin
                    if (idle_ok) begin
                        TX_DONE  <= ack_ok;
                        TX_ERROR <= ~ack_ok;
                        TX_BUSY  <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Device watchdog; a fall always wins over an expiring count.
            if (state inside {SHIFT, ACK, WAIT_IDLE}) begin
                if (fall) begin
                    to_cnt <= '0;
                end else if (timed_out && !idle_ok) begin
                    PS2_CLK_OE  <= 1'b0;
                    PS2_DATA_OE <= 1'b0;
                    TX_ERROR    <= 1'b1;
                    TX_DONE     <= 1'b0;
                    TX_BUSY     <= 1'b0;
                    state       <= IDLE;
                end else if (to_cnt != TO_MAX) begin
                    to_cnt <= to_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a device model clocks frames out of the host and
// compares them against a scoreboard of expected frames and outcomes.
module tb_ps2_host_tx;

    localparam int INH  = 100;
    localparam int TMO  = 3000;
    localparam int HALF = 20;

    typedef struct {
        logic [7:0] data;
        logic       ack;
        logic       parity;
        logic       done;
    } vec_t;

    typedef struct {
        logic [10:0] frame;
        logic        ack;
    } exp_t;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic [7:0] TX_DATA = 8'h00;
    logic       TX_VALID = 1'b0;
    logic       TX_READY, TX_BUSY, TX_DONE, TX_ERROR;
    logic       PS2_CLK_OE, PS2_DATA_OE;
    logic       ps2_clk, ps2_data;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;

    int checks = 0;
    int failures = 0;
    exp_t exp_q[$];

    int   cycle = 0, done_cnt = 0, err_cnt = 0, both_cnt = 0;
    int   oe_run = 0, inhibit_len = 0, release_cycle = 0, error_cycle = 0;
    logic prev_clk_oe = 1'b0, last_data_oe = 1'b0, data_oe_at_release = 1'b0;

    assign ps2_clk  = ~(PS2_CLK_OE | dev_clk_low);
    assign ps2_data = ~(PS2_DATA_OE | dev_data_low);

    always #5 CLK = ~CLK;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
        .CLK(CLK), .RESET(RESET), .TX_DATA(TX_DATA), .TX_VALID(TX_VALID),
        .TX_READY(TX_READY), .TX_BUSY(TX_BUSY), .TX_DONE(TX_DONE), .TX_ERROR(TX_ERROR),
        .PS2_CLK_IN(ps2_clk), .PS2_DATA_IN(ps2_data),
        .PS2_CLK_OE(PS2_CLK_OE), .PS2_DATA_OE(PS2_DATA_OE)
    );

    // Pulse counters and inhibit-window measurements, sampled just after each edge.
    always @(posedge CLK) begin
        #1;
        cycle++;
        if (TX_DONE) done_cnt++;
        if (TX_ERROR) begin
            err_cnt++;
            error_cycle = cycle;
        end
        if (TX_DONE && TX_ERROR) both_cnt++;
        if (PS2_CLK_OE) begin
            oe_run++;
            last_data_oe = PS2_DATA_OE;
        end else if (prev_clk_oe) begin
            inhibit_len        = oe_run;
            data_oe_at_release = last_data_oe;
            release_cycle      = cycle;
            oe_run             = 0;
        end
        prev_clk_oe = PS2_CLK_OE;
    end

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [10:0] frame_of(input logic [7:0] d, input logic p);
        return {1'b1, p, d, 1'b0};
    endfunction

    task automatic check_val(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input logic [7:0] d, input logic p, input logic ack);
        int n = 0;
        @(negedge CLK);
        TX_DATA  = d;
        TX_VALID = 1'b1;
        while (!TX_READY && n < 200) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 200) check_val("handshake_wait", 0, 1);
        exp_q.push_back('{frame: frame_of(d, p), ack: ack});
        @(negedge CLK);
        TX_VALID = 1'b0;
    endtask

    // Device side: waits for the host request, then issues n_clk clock pulses,
    // sampling the data line just before each falling edge.
    task automatic device_clocks(input int n_clk, input logic ack, output logic [10:0] bits);
        int n = 0;
        bits = '0;
        while (!PS2_CLK_OE && n < 200) begin
            @(negedge CLK);
            n++;
        end
        n = 0;
        while (PS2_CLK_OE && n < INH + 50) begin
            @(negedge CLK);
            n++;
        end
        if (n >= INH + 50) begin
            check_val("request_wait", 0, 1);
            return;
        end
        for (int i = 0; i < n_clk; i++) begin
            repeat (HALF) @(negedge CLK);
            bits[i] = ps2_data;
            if (i == 10 && ack) dev_data_low = 1'b1;
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge CLK);
            dev_clk_low = 1'b0;
        end
    endtask

    task automatic check_output(input string tag, input logic [10:0] bits, input int done0, input int err0);
        exp_t e;
        int   n = 0;
        repeat (HALF) @(negedge CLK);
        dev_data_low = 1'b0;
        while ((done_cnt + err_cnt) == (done0 + err0) && n < 200) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 200) check_val({tag, "_pulse_wait"}, 0, 1);
        if (exp_q.size() == 0) begin
            check_val({tag, "_scoreboard_empty"}, 0, 1);
            return;
        end
        e = exp_q.pop_front();
        check_val({tag, "_frame"}, 32'(bits), 32'(e.frame));
        check_val({tag, "_done_pulses"}, done_cnt - done0, 32'(e.ack));
        check_val({tag, "_error_pulses"}, err_cnt - err0, 32'(!e.ack));
        check_val({tag, "_inhibit_len"}, inhibit_len, INH);
        check_val({tag, "_start_before_release"}, 32'(data_oe_at_release), 1);
        check_val({tag, "_busy_after"}, 32'(TX_BUSY), 0);
        check_val({tag, "_oe_after"}, {30'd0, PS2_CLK_OE, PS2_DATA_OE}, 0);
        @(negedge CLK);
        check_val({tag, "_ready_after"}, 32'(TX_READY), 1);
    endtask

    initial begin
        vec_t        vecs[5];
        logic [10:0] bits;
        int          d0, e0, n;

        vecs[0] = '{data: 8'hED, ack: 1'b1, parity: 1'b1, done: 1'b1};
        vecs[1] = '{data: 8'h00, ack: 1'b1, parity: 1'b1, done: 1'b1};
        vecs[2] = '{data: 8'h01, ack: 1'b1, parity: 1'b0, done: 1'b1};
        vecs[3] = '{data: 8'hFF, ack: 1'b1, parity: 1'b1, done: 1'b1};
        vecs[4] = '{data: 8'h3C, ack: 1'b0, parity: 1'b1, done: 1'b0};

        repeat (3) @(negedge CLK);
        check_val("reset_ready", 32'(TX_READY), 0);
        check_val("reset_busy", 32'(TX_BUSY), 0);
        check_val("reset_pulses", {30'd0, TX_DONE, TX_ERROR}, 0);
        check_val("reset_oe", {30'd0, PS2_CLK_OE, PS2_DATA_OE}, 0);
        RESET = 1'b1;
        @(negedge CLK);
        check_val("ready_after_reset", 32'(TX_READY), 1);

        for (int i = 0; i < 5; i++) begin
            d0 = done_cnt;
            e0 = err_cnt;
            apply_stimulus(vecs[i].data, vecs[i].parity, vecs[i].ack);
            device_clocks(11, vecs[i].ack, bits);
            check_output($sformatf("vec%0d", i), bits, d0, e0);
            check_val($sformatf("vec%0d_outcome", i), 32'(done_cnt - d0 == 1), 32'(vecs[i].done));
        end

        // Device never clocks: the host must give up exactly TMO cycles after release.
        d0 = done_cnt;
        e0 = err_cnt;
        apply_stimulus(8'h12, 1'b1, 1'b0);
        n = 0;
        while (err_cnt == e0 && n < INH + TMO + 100) begin
            @(negedge CLK);
            n++;
        end
        check_val("timeout_pulse", err_cnt - e0, 1);
        check_val("timeout_latency", error_cycle - release_cycle, TMO);
        check_val("timeout_oe", {30'd0, PS2_CLK_OE, PS2_DATA_OE}, 0);
        check_val("timeout_no_done", done_cnt - d0, 0);
        @(negedge CLK);
        check_val("timeout_ready_next", 32'(TX_READY), 1);
        void'(exp_q.pop_front());

        // Reset after fall 5 of 0x0F: D4=0 is being driven low at that point.
        d0 = done_cnt;
        e0 = err_cnt;
        apply_stimulus(8'h0F, 1'b1, 1'b1);
        device_clocks(5, 1'b0, bits);
        repeat (5) @(negedge CLK);
        check_val("midframe_data_oe", 32'(PS2_DATA_OE), 1);
        RESET = 1'b0;
        #1;
        check_val("midframe_reset_oe", {30'd0, PS2_CLK_OE, PS2_DATA_OE}, 0);
        check_val("midframe_reset_busy", 32'(TX_BUSY), 0);
        repeat (3) @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        check_val("midframe_no_pulses", (done_cnt - d0) + (err_cnt - e0), 0);
        void'(exp_q.pop_front());
        d0 = done_cnt;
        e0 = err_cnt;
        apply_stimulus(8'hF4, 1'b0, 1'b1);
        device_clocks(11, 1'b1, bits);
        check_output("after_reset_f4", bits, d0, e0);

        // TX_VALID stays high with 0xAA queued behind an in-flight 0x55.
        d0 = done_cnt;
        e0 = err_cnt;
        @(negedge CLK);
        TX_DATA  = 8'h55;
        TX_VALID = 1'b1;
        n = 0;
        while (!TX_READY && n < 200) begin
            @(negedge CLK);
            n++;
        end
        exp_q.push_back('{frame: frame_of(8'h55, 1'b1), ack: 1'b1});
        @(negedge CLK);
        TX_DATA = 8'hAA;
        device_clocks(11, 1'b1, bits);
        check_output("busy_55", bits, d0, e0);
        exp_q.push_back('{frame: frame_of(8'hAA, 1'b1), ack: 1'b1});
        d0 = done_cnt;
        e0 = err_cnt;
        @(negedge CLK);
        check_val("busy_accept_aa", 32'(TX_BUSY), 1);
        TX_VALID = 1'b0;
        device_clocks(11, 1'b1, bits);
        check_output("busy_aa", bits, d0, e0);

        check_val("done_and_error_together", both_cnt, 0);
        check_val("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
